// File: rtl/axis_adc_packer_pkg.sv
// Shared defaults and types for the dual-channel ADC sample packer.
package axis_adc_packer_pkg;

    localparam int ADC_WIDTH_DEF   = 16;
    localparam int TDATA_WIDTH_DEF = 4 * ADC_WIDTH_DEF;
    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int DEC_WIDTH       = 16;
    localparam int DROP_CNT_WIDTH  = 32;

    // LOW: no partial beat held; HIGH: low half of the next beat sits in lo_reg
    typedef enum logic {
        PACK_LOW  = 1'b0,
        PACK_HIGH = 1'b1
    } pack_state_t;

    // Last value of the decimation counter before it wraps; 0 and 1 both keep every pair
    function automatic logic [DEC_WIDTH-1:0] dec_limit(input logic [DEC_WIDTH-1:0] decimation);
        if (decimation <= 16'd1) begin
            return '0;
        end
        return decimation - 16'd1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always
// presented on rd_data while empty is low; a pop advances to the next entry.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop together
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/axis_adc_packer.sv
// Packs two consecutive kept ADC sample pairs into one AXI4-Stream beat,
// with optional decimation, an output FIFO and drop/overflow status.
module axis_adc_packer
    import axis_adc_packer_pkg::*;
#(
    parameter int ADC_WIDTH   = ADC_WIDTH_DEF,
    parameter int TDATA_WIDTH = 4 * ADC_WIDTH,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ADC_WIDTH-1:0]   adc0,
    input  logic [ADC_WIDTH-1:0]   adc1,
    input  logic                   adc_valid,
    input  logic                   enable,
    input  logic [15:0]            decimation,
    input  logic                   clear_status,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   overflow,
    output logic [31:0]            drop_count
);

    localparam int PAIR_W = 2 * ADC_WIDTH;

    pack_state_t           state_reg;
    pack_state_t           state_next;
    logic [PAIR_W-1:0]     lo_reg;
    logic [PAIR_W-1:0]     lo_next;
    logic [DEC_WIDTH-1:0]  dec_cnt_reg;
    logic [DEC_WIDTH-1:0]  dec_cnt_next;
    logic                  overflow_reg;
    logic [31:0]           drop_count_reg;

    logic [PAIR_W-1:0]      pair_word;
    logic                   offered;
    logic                   keep;
    logic                   push_req;
    logic [TDATA_WIDTH-1:0] push_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   drop;

    assign pair_word = {adc1, adc0};
    assign offered   = enable && adc_valid;
    assign keep      = offered && (dec_cnt_reg == '0);

    // Decimation counter; the >= wrap lets a lowered ratio take effect without stalling
    always_comb begin
        dec_cnt_next = dec_cnt_reg;
        if (!enable) begin
            dec_cnt_next = '0;
        end else if (offered) begin
            if (dec_cnt_reg >= dec_limit(decimation)) begin
                dec_cnt_next = '0;
            end else begin
                dec_cnt_next = dec_cnt_reg + 1'b1;
            end
        end
    end

    // Pack FSM next-state: first kept pair is parked, second completes a beat
    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        push_req   = 1'b0;
        push_data  = {pair_word, lo_reg};
        if (!enable) begin
            state_next = PACK_LOW;
            lo_next    = '0;
        end else if (keep) begin
            case (state_reg)
                PACK_LOW: begin
                    lo_next    = pair_word;
                    state_next = PACK_HIGH;
                end
                PACK_HIGH: begin
                    push_req   = 1'b1;
                    state_next = PACK_LOW;
                end
                default: begin
                    state_next = PACK_LOW;
                end
            endcase
        end
    end

    // Pack FSM and decimation state registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= PACK_LOW;
            lo_reg      <= '0;
            dec_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            lo_reg      <= lo_next;
            dec_cnt_reg <= dec_cnt_next;
        end
    end

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign drop = push_req && fifo_full && !pop;

    // Sticky overflow and saturating drop counter; a drop beats a simultaneous clear
    always_ff @(posedge aclk) begin
        if (areset) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (clear_status) begin
                drop_count_reg <= 32'd1;
            end else if (drop_count_reg != 32'hFFFF_FFFF) begin
                drop_count_reg <= drop_count_reg + 32'd1;
            end
        end else if (clear_status) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end
    end

    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

    axis_sync_fifo #(
        .WIDTH (TDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (push_req),
        .wr_data (push_data),
        .rd_en   (m_axis_tready),
        .rd_data (m_axis_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;

endmodule

// File: tb/tb_axis_adc_packer.sv
// Directed bench for axis_adc_packer: drives inputs 1 time unit after the
// rising edge and samples outputs at the same point.
module tb_axis_adc_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] adc0;
    logic [15:0] adc1;
    logic        adc_valid;
    logic        enable;
    logic [15:0] decimation;
    logic        clear_status;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        overflow;
    logic [31:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_adc_packer dut (
        .aclk          (aclk),
        .areset        (areset),
        .adc0          (adc0),
        .adc1          (adc1),
        .adc_valid     (adc_valid),
        .enable        (enable),
        .decimation    (decimation),
        .clear_status  (clear_status),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    task automatic check_equal(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_pair(input logic [15:0] a0, input logic [15:0] a1);
        adc0      = a0;
        adc1      = a1;
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    // Beat k of the stream adc0=i, adc1=0x100+i
    function automatic logic [63:0] fill_beat(input int k);
        logic [15:0] l0, l1, h0, h1;
        l0 = 16'(2 * k);
        l1 = 16'(256 + 2 * k);
        h0 = 16'(2 * k + 1);
        h1 = 16'(256 + 2 * k + 1);
        return {h1, h0, l1, l0};
    endfunction

    logic [63:0] first_beat;
    logic [63:0] last_beat;
    int          n_beats;

    initial begin
        areset        = 1'b1;
        adc0          = '0;
        adc1          = '0;
        adc_valid     = 1'b0;
        enable        = 1'b0;
        decimation    = 16'd1;
        clear_status  = 1'b0;
        m_axis_tready = 1'b0;
        step();
        step();
        check_equal("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_equal("reset_overflow", 64'(overflow), 64'd0);
        check_equal("reset_drop_count", 64'(drop_count), 64'd0);
        areset = 1'b0;
        step();

        // Scenario 1: two pairs make one beat, visible the cycle after the second
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        send_pair(16'h0001, 16'h0002);
        check_equal("s1_no_beat_after_first_pair", 64'(m_axis_tvalid), 64'd0);
        send_pair(16'h0003, 16'h0004);
        check_equal("s1_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_equal("s1_tdata", m_axis_tdata, 64'h0004_0003_0002_0001);
        step();
        check_equal("s1_drained", 64'(m_axis_tvalid), 64'd0);

        // Scenario 2: decimation by 3 keeps adc0 = 0,3,6,9
        m_axis_tready = 1'b0;
        decimation    = 16'd3;
        restart();
        for (int i = 0; i < 12; i++) begin
            send_pair(16'(i), 16'(100 + i));
        end
        check_equal("s2_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_equal("s2_beat0", m_axis_tdata, {16'd103, 16'd3, 16'd100, 16'd0});
        m_axis_tready = 1'b1;
        step();
        check_equal("s2_beat1", m_axis_tdata, {16'd109, 16'd9, 16'd106, 16'd6});
        step();
        check_equal("s2_only_two_beats", 64'(m_axis_tvalid), 64'd0);

        // Scenario 3: overfill with ready low, then drain in order
        m_axis_tready = 1'b0;
        decimation    = 16'd1;
        restart();
        for (int i = 0; i < 40; i++) begin
            send_pair(16'(i), 16'(256 + i));
        end
        check_equal("s3_overflow", 64'(overflow), 64'd1);
        check_equal("s3_drop_count", 64'(drop_count), 64'd4);
        m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_equal($sformatf("s3_drain_beat%0d", k), m_axis_tdata, fill_beat(k));
            step();
        end
        check_equal("s3_empty_after_16", 64'(m_axis_tvalid), 64'd0);
        m_axis_tready = 1'b0;
        clear_status  = 1'b1;
        step();
        clear_status  = 1'b0;
        check_equal("s3_clear_overflow", 64'(overflow), 64'd0);
        check_equal("s3_clear_drop_count", 64'(drop_count), 64'd0);

        // Scenario 4: disabling discards the parked half beat
        restart();
        send_pair(16'h00AA, 16'h00BB);
        enable = 1'b0;
        send_pair(16'h00CC, 16'h00DD);
        enable = 1'b1;
        send_pair(16'h0011, 16'h0022);
        check_equal("s4_no_beat_yet", 64'(m_axis_tvalid), 64'd0);
        send_pair(16'h0033, 16'h0044);
        check_equal("s4_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_equal("s4_tdata", m_axis_tdata, 64'h0044_0033_0022_0011);
        m_axis_tready = 1'b1;
        step();
        check_equal("s4_single_beat", 64'(m_axis_tvalid), 64'd0);

        // Scenario 5: push into a full FIFO during a pop is not dropped
        m_axis_tready = 1'b0;
        restart();
        for (int i = 0; i < 32; i++) begin
            send_pair(16'(i), 16'(256 + i));
        end
        check_equal("s5_full_no_drop", 64'(drop_count), 64'd0);
        send_pair(16'h00F0, 16'h00F1);
        m_axis_tready = 1'b1;
        send_pair(16'h00F2, 16'h00F3);
        m_axis_tready = 1'b0;
        check_equal("s5_overflow", 64'(overflow), 64'd0);
        check_equal("s5_drop_count", 64'(drop_count), 64'd0);
        m_axis_tready = 1'b1;
        n_beats    = 0;
        first_beat = '0;
        last_beat  = '0;
        while (m_axis_tvalid && n_beats < 40) begin
            if (n_beats == 0) first_beat = m_axis_tdata;
            last_beat = m_axis_tdata;
            n_beats++;
            step();
        end
        check_equal("s5_occupancy", 64'(n_beats), 64'd16);
        check_equal("s5_first_beat", first_beat, fill_beat(1));
        check_equal("s5_last_beat", last_beat, 64'h00F3_00F2_00F1_00F0);

        // Scenario 6: reset mid-run flushes buffered beats and the partial half
        m_axis_tready = 1'b0;
        restart();
        for (int i = 0; i < 11; i++) begin
            send_pair(16'(i), 16'(256 + i));
        end
        check_equal("s6_buffered", 64'(m_axis_tvalid), 64'd1);
        areset = 1'b1;
        step();
        check_equal("s6_reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_equal("s6_reset_overflow", 64'(overflow), 64'd0);
        check_equal("s6_reset_drop_count", 64'(drop_count), 64'd0);
        areset = 1'b0;
        step();
        step();
        check_equal("s6_no_stale_beats", 64'(m_axis_tvalid), 64'd0);
        send_pair(16'h0005, 16'h0006);
        send_pair(16'h0007, 16'h0008);
        check_equal("s6_fresh_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_equal("s6_fresh_tdata", m_axis_tdata, 64'h0008_0007_0006_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
